// File: rtl/decode_field_pipe.sv
// decode_field_pipe: registered IF/ID field distributor for the MIPS pipeline.
// Splits one fetched instruction per handshake into its opcode, register and
// function fields. Also produces the extended immediate, the jump and branch
// targets and the write-back register index. Everything is held in a single
// valid/ready stage with flush.
module decode_field_pipe #(
    parameter int unsigned NB_DATA      = 32,
    parameter int unsigned NB_PC        = 32,
    parameter int unsigned NB_OP        = 6,
    parameter int unsigned NB_FUNCT     = 6,
    parameter int unsigned NB_INM       = 16,
    parameter int unsigned NB_REG       = 5,
    parameter int unsigned NB_DIRECTION = 26,
    parameter int unsigned RA_INDEX     = 31
) (
    input  logic                clock,
    input  logic                reset_n,

    // upstream handshake
    input  logic                i_valid,
    output logic                o_ready,
    input  logic [NB_DATA-1:0]  i_instruction,
    input  logic [NB_PC-1:0]    i_pc_next,
    input  logic                i_flush,

    // downstream handshake
    output logic                o_valid,
    input  logic                i_ready,

    // decoded fields
    output logic [NB_OP-1:0]    o_operation,
    output logic [NB_FUNCT-1:0] o_funct,
    output logic [NB_REG-1:0]   o_rs,
    output logic [NB_REG-1:0]   o_rt,
    output logic [NB_REG-1:0]   o_rd,
    output logic [NB_REG-1:0]   o_shamt,
    output logic [NB_DATA-1:0]  o_imm_ext,
    output logic [NB_PC-1:0]    o_jump_target,
    output logic [NB_PC-1:0]    o_branch_target,
    output logic [NB_REG-1:0]   o_dest_reg,
    output logic [NB_PC-1:0]    o_pc_next
);

    // Bit positions of each field inside the instruction word.
    localparam int unsigned SHAMT_LSB = NB_FUNCT;
    localparam int unsigned RD_LSB    = NB_FUNCT + NB_REG;
    localparam int unsigned RT_LSB    = NB_FUNCT + 2 * NB_REG;
    localparam int unsigned RS_LSB    = NB_FUNCT + 3 * NB_REG;
    localparam int unsigned OP_LSB    = NB_FUNCT + 4 * NB_REG;

    // Opcodes that change immediate extension or destination selection.
    localparam logic [NB_OP-1:0] OP_RTYPE = NB_OP'(6'h00);
    localparam logic [NB_OP-1:0] OP_JAL   = NB_OP'(6'h03);
    localparam logic [NB_OP-1:0] OP_ANDI  = NB_OP'(6'h0C);
    localparam logic [NB_OP-1:0] OP_ORI   = NB_OP'(6'h0D);
    localparam logic [NB_OP-1:0] OP_XORI  = NB_OP'(6'h0E);
    localparam logic [NB_OP-1:0] OP_LUI   = NB_OP'(6'h0F);

    // Jump keeps the PC bits above the 256 MB region boundary.
    localparam logic [NB_PC-1:0] JUMP_LOW_MASK = NB_PC'(28'hFFF_FFFF);

    // ------------------------------------------------------------------
    // Field extraction and target computation on the incoming word
    // ------------------------------------------------------------------
    logic [NB_OP-1:0]        in_op;
    logic [NB_FUNCT-1:0]     in_funct;
    logic [NB_REG-1:0]       in_rs;
    logic [NB_REG-1:0]       in_rt;
    logic [NB_REG-1:0]       in_rd;
    logic [NB_REG-1:0]       in_shamt;
    logic [NB_INM-1:0]       in_imm;
    logic [NB_DIRECTION-1:0] in_direction;

    assign in_op        = i_instruction[OP_LSB +: NB_OP];
    assign in_funct     = i_instruction[NB_FUNCT-1:0];
    assign in_rs        = i_instruction[RS_LSB +: NB_REG];
    assign in_rt        = i_instruction[RT_LSB +: NB_REG];
    assign in_rd        = i_instruction[RD_LSB +: NB_REG];
    assign in_shamt     = i_instruction[SHAMT_LSB +: NB_REG];
    assign in_imm       = i_instruction[NB_INM-1:0];
    assign in_direction = i_instruction[NB_DIRECTION-1:0];

    logic [NB_DATA-1:0] imm_sext;
    logic [NB_DATA-1:0] imm_zext;
    logic [NB_DATA-1:0] imm_upper;
    logic [NB_DATA-1:0] imm_ext_d;
    logic [NB_PC-1:0]   imm_pc_sext;
    logic [NB_PC-1:0]   branch_target_d;
    logic [NB_PC-1:0]   jump_target_d;
    logic [NB_REG-1:0]  dest_reg_d;

    assign imm_sext    = {{(NB_DATA - NB_INM){in_imm[NB_INM-1]}}, in_imm};
    assign imm_zext    = {{(NB_DATA - NB_INM){1'b0}}, in_imm};
    // lui: immediate in the upper half, anything above bit 31 follows its sign
    assign imm_upper   = imm_sext << NB_INM;
    assign imm_pc_sext = {{(NB_PC - NB_INM){in_imm[NB_INM-1]}}, in_imm};

    // Branch offset is word-aligned; the add wraps silently modulo 2^NB_PC.
    assign branch_target_d = i_pc_next + (imm_pc_sext << 2);
    assign jump_target_d   = (i_pc_next & ~JUMP_LOW_MASK) | NB_PC'({in_direction, 2'b00});

    // Select the immediate extension mode from the opcode.
    always_comb begin
        imm_ext_d = imm_sext;
        case (in_op)
            OP_ANDI, OP_ORI, OP_XORI: imm_ext_d = imm_zext;
            OP_LUI:                   imm_ext_d = imm_upper;
            default:                  imm_ext_d = imm_sext;
        endcase
    end

    // Select the write-back register: rd for R-type, link register for jal, rt otherwise.
    always_comb begin
        dest_reg_d = in_rt;
        case (in_op)
            OP_RTYPE: dest_reg_d = in_rd;
            OP_JAL:   dest_reg_d = NB_REG'(RA_INDEX);
            default:  dest_reg_d = in_rt;
        endcase
    end

    // ------------------------------------------------------------------
    // Pipeline register
    // ------------------------------------------------------------------
    logic valid_q;
    logic load;

    // Flush also opens the stage so upstream never stalls on a killed slot.
    assign o_ready = ~valid_q | i_ready | i_flush;
    assign load    = i_valid & o_ready & ~i_flush;

    // Valid bit: flush wins, then load, then drain; otherwise hold.
    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            valid_q <= 1'b0;
        end else if (i_flush) begin
            valid_q <= 1'b0;
        end else if (load) begin
            valid_q <= 1'b1;
        end else if (valid_q && i_ready) begin
            valid_q <= 1'b0;
        end
    end

    // Decoded field registers only change on a load; drained values are stale.
    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            o_operation     <= '0;
            o_funct         <= '0;
            o_rs            <= '0;
            o_rt            <= '0;
            o_rd            <= '0;
            o_shamt         <= '0;
            o_imm_ext       <= '0;
            o_jump_target   <= '0;
            o_branch_target <= '0;
            o_dest_reg      <= '0;
            o_pc_next       <= '0;
        end else if (load) begin
            o_operation     <= in_op;
            o_funct         <= in_funct;
            o_rs            <= in_rs;
            o_rt            <= in_rt;
            o_rd            <= in_rd;
            o_shamt         <= in_shamt;
            o_imm_ext       <= imm_ext_d;
            o_jump_target   <= jump_target_d;
            o_branch_target <= branch_target_d;
            o_dest_reg      <= dest_reg_d;
            o_pc_next       <= i_pc_next;
        end
    end

    assign o_valid = valid_q;

endmodule

// File: tb/tb_decode_field_pipe.sv
// Directed self-checking bench for decode_field_pipe.
module tb_decode_field_pipe;

    logic        clock;
    logic        reset_n;
    logic        i_valid;
    logic        o_ready;
    logic [31:0] i_instruction;
    logic [31:0] i_pc_next;
    logic        i_flush;
    logic        o_valid;
    logic        i_ready;
    logic [5:0]  o_operation;
    logic [5:0]  o_funct;
    logic [4:0]  o_rs;
    logic [4:0]  o_rt;
    logic [4:0]  o_rd;
    logic [4:0]  o_shamt;
    logic [31:0] o_imm_ext;
    logic [31:0] o_jump_target;
    logic [31:0] o_branch_target;
    logic [4:0]  o_dest_reg;
    logic [31:0] o_pc_next;

    int checks;
    int failures;

    decode_field_pipe dut (
        .clock           (clock),
        .reset_n         (reset_n),
        .i_valid         (i_valid),
        .o_ready         (o_ready),
        .i_instruction   (i_instruction),
        .i_pc_next       (i_pc_next),
        .i_flush         (i_flush),
        .o_valid         (o_valid),
        .i_ready         (i_ready),
        .o_operation     (o_operation),
        .o_funct         (o_funct),
        .o_rs            (o_rs),
        .o_rt            (o_rt),
        .o_rd            (o_rd),
        .o_shamt         (o_shamt),
        .o_imm_ext       (o_imm_ext),
        .o_jump_target   (o_jump_target),
        .o_branch_target (o_branch_target),
        .o_dest_reg      (o_dest_reg),
        .o_pc_next       (o_pc_next)
    );

    initial clock = 1'b0;
    always #5 clock = ~clock;

    task automatic check_eq(input string tag, input logic [63:0] got, input logic [63:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    // Advance one clock and settle past the edge.
    task automatic step();
        @(posedge clock);
        #1;
    endtask

    task automatic drive(input logic v, input logic [31:0] instr, input logic [31:0] pc,
                         input logic rdy, input logic fl);
        i_valid       = v;
        i_instruction = instr;
        i_pc_next     = pc;
        i_ready       = rdy;
        i_flush       = fl;
    endtask

    task automatic check_reset_state(input string tag);
        check_eq({tag, " o_valid"},         64'(o_valid), 64'd0);
        check_eq({tag, " o_ready"},         64'(o_ready), 64'd1);
        check_eq({tag, " o_operation"},     64'(o_operation), 64'd0);
        check_eq({tag, " o_rs"},            64'(o_rs), 64'd0);
        check_eq({tag, " o_rt"},            64'(o_rt), 64'd0);
        check_eq({tag, " o_rd"},            64'(o_rd), 64'd0);
        check_eq({tag, " o_funct"},         64'(o_funct), 64'd0);
        check_eq({tag, " o_imm_ext"},       64'(o_imm_ext), 64'd0);
        check_eq({tag, " o_jump_target"},   64'(o_jump_target), 64'd0);
        check_eq({tag, " o_branch_target"}, 64'(o_branch_target), 64'd0);
        check_eq({tag, " o_dest_reg"},      64'(o_dest_reg), 64'd0);
        check_eq({tag, " o_pc_next"},       64'(o_pc_next), 64'd0);
    endtask

    initial begin
        checks   = 0;
        failures = 0;
        reset_n  = 1'b0;
        drive(1'b0, 32'h0, 32'h0, 1'b1, 1'b0);
        #3;
        check_reset_state("reset");
        #9 reset_n = 1'b1;

        // addi $8, $9, -1
        drive(1'b1, 32'h2128FFFF, 32'h00400004, 1'b1, 1'b0);
        step();
        check_eq("addi valid",   64'(o_valid), 64'd1);
        check_eq("addi op",      64'(o_operation), 64'h08);
        check_eq("addi rs",      64'(o_rs), 64'd9);
        check_eq("addi rt",      64'(o_rt), 64'd8);
        check_eq("addi imm",     64'(o_imm_ext), 64'hFFFFFFFF);
        check_eq("addi dest",    64'(o_dest_reg), 64'd8);
        check_eq("addi btarget", 64'(o_branch_target), 64'h00400000);
        check_eq("addi pc",      64'(o_pc_next), 64'h00400004);

        // ori then lui back to back, no bubble
        drive(1'b1, 32'h34028000, 32'h00400008, 1'b1, 1'b0);
        step();
        check_eq("ori valid", 64'(o_valid), 64'd1);
        check_eq("ori imm",   64'(o_imm_ext), 64'h00008000);
        check_eq("ori dest",  64'(o_dest_reg), 64'd2);
        drive(1'b1, 32'h3C011234, 32'h0040000C, 1'b1, 1'b0);
        step();
        check_eq("lui valid", 64'(o_valid), 64'd1);
        check_eq("lui imm",   64'(o_imm_ext), 64'h12340000);
        check_eq("lui dest",  64'(o_dest_reg), 64'd1);
        check_eq("lui op",    64'(o_operation), 64'h0F);

        // add $3, $1, $2 then stall three cycles with a new word pending
        drive(1'b1, 32'h00221820, 32'h00400010, 1'b1, 1'b0);
        step();
        drive(1'b1, 32'h3C01FFFF, 32'h00400014, 1'b0, 1'b0);
        #1;
        for (int i = 0; i < 3; i++) begin
            check_eq("stall ready", 64'(o_ready), 64'd0);
            check_eq("stall valid", 64'(o_valid), 64'd1);
            check_eq("stall rs",    64'(o_rs), 64'd1);
            check_eq("stall rt",    64'(o_rt), 64'd2);
            check_eq("stall rd",    64'(o_rd), 64'd3);
            check_eq("stall funct", 64'(o_funct), 64'h20);
            check_eq("stall dest",  64'(o_dest_reg), 64'd3);
            check_eq("stall op",    64'(o_operation), 64'h00);
            check_eq("stall imm",   64'(o_imm_ext), 64'h00001820);
            step();
        end
        // Release with no new word: drains, pending lui was never consumed
        drive(1'b0, 32'h3C01FFFF, 32'h00400014, 1'b1, 1'b0);
        step();
        check_eq("drain valid", 64'(o_valid), 64'd0);
        check_eq("drain op",    64'(o_operation), 64'h00);

        // jal then beq back to back
        drive(1'b1, 32'h0C100000, 32'h00400004, 1'b1, 1'b0);
        step();
        check_eq("jal jtarget", 64'(o_jump_target), 64'h00400000);
        check_eq("jal dest",    64'(o_dest_reg), 64'd31);
        drive(1'b1, 32'h1022FFFE, 32'h00400010, 1'b1, 1'b0);
        step();
        check_eq("beq valid",   64'(o_valid), 64'd1);
        check_eq("beq btarget", 64'(o_branch_target), 64'h00400008);
        check_eq("beq dest",    64'(o_dest_reg), 64'd2);

        // Boundaries: branch wrap-around, negative lui, andi zero-extend,
        // jump keeping upper PC bits, sll shamt
        drive(1'b1, 32'h10000001, 32'hFFFFFFFC, 1'b1, 1'b0);
        step();
        check_eq("wrap btarget", 64'(o_branch_target), 64'h00000000);
        drive(1'b1, 32'h3C01FFFF, 32'h00400020, 1'b1, 1'b0);
        step();
        check_eq("lui neg imm", 64'(o_imm_ext), 64'hFFFF0000);
        drive(1'b1, 32'h3000FFFF, 32'h00400024, 1'b1, 1'b0);
        step();
        check_eq("andi imm", 64'(o_imm_ext), 64'h0000FFFF);
        check_eq("andi op",  64'(o_operation), 64'h0C);
        drive(1'b1, 32'h0C000001, 32'hA0000008, 1'b1, 1'b0);
        step();
        check_eq("jal hi jtarget", 64'(o_jump_target), 64'hA0000004);
        drive(1'b1, 32'h00031080, 32'h0040002C, 1'b1, 1'b0);
        step();
        check_eq("sll shamt", 64'(o_shamt), 64'd2);
        check_eq("sll rd",    64'(o_rd), 64'd2);
        check_eq("sll rt",    64'(o_rt), 64'd3);
        check_eq("sll dest",  64'(o_dest_reg), 64'd2);

        // xori held under stall, then flush with an incoming addi
        drive(1'b1, 32'h3842ABCD, 32'h00400030, 1'b1, 1'b0);
        step();
        check_eq("xori imm", 64'(o_imm_ext), 64'h0000ABCD);
        drive(1'b0, 32'h0, 32'h0, 1'b0, 1'b0);
        step();
        check_eq("pre-flush valid", 64'(o_valid), 64'd1);
        drive(1'b1, 32'h20000001, 32'h00400034, 1'b0, 1'b1);
        #1;
        check_eq("flush ready", 64'(o_ready), 64'd1);
        step();
        check_eq("flush valid", 64'(o_valid), 64'd0);
        check_eq("flush op",    64'(o_operation), 64'h0E);
        drive(1'b0, 32'h0, 32'h0, 1'b1, 1'b0);
        step();
        check_eq("post-flush valid", 64'(o_valid), 64'd0);

        // Asynchronous reset in the middle of a stall
        drive(1'b1, 32'h2128FFFF, 32'h00400040, 1'b1, 1'b0);
        step();
        drive(1'b0, 32'h0, 32'h0, 1'b0, 1'b0);
        step();
        check_eq("pre-reset valid", 64'(o_valid), 64'd1);
        #2 reset_n = 1'b0;
        #1;
        check_reset_state("async reset");

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
